// File: rtl/psum_ctrl_pkg.sv
// psum_ctrl_pkg: shared FSM state encodings, adder mode codes and datapath widths for psum_ctrl.
package psum_ctrl_pkg;

    localparam int PIX_BITS      = 10;
    localparam int CH_BITS       = 8;
    localparam int DATA_BITS     = 8;
    localparam int INTERNAL_BITS = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_ACC,
        S_LAST,
        S_FIN
    } state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FIRST = 2'b00;
    localparam mode_t MODE_ACC   = 2'b01;
    localparam mode_t MODE_LAST  = 2'b10;

    // Adder mode associated with a pass state; IDLE/FIN map to 00.
    function automatic mode_t state_mode(input state_t s);
        return (s == S_ACC) ? MODE_ACC : (s == S_LAST) ? MODE_LAST : MODE_FIRST;
    endfunction

endpackage

// File: rtl/psum_addr_gen.sv
// psum_addr_gen: pixel/channel counters with wrap logic and latched job geometry.
//   clk, rst       clock, asynchronous active-high reset
//   load           accepted start: latch num_ch/num_pix, clear counters
//   num_ch/num_pix job geometry sampled on load
//   adv            one accepted beat
//   pix, ch        current pixel and channel-pass counters
//   pix_last       pix is the final pixel of the pass
//   next_last      the pass after this one is the final pass
//   one_pix        job has a single pixel per pass
module psum_addr_gen
    import psum_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CH_BITS-1:0]  num_ch,
    input  logic [PIX_BITS-1:0] num_pix,
    input  logic                adv,
    output logic [PIX_BITS-1:0] pix,
    output logic [CH_BITS-1:0]  ch,
    output logic                pix_last,
    output logic                next_last,
    output logic                one_pix
);

    logic [CH_BITS-1:0]  nch_q;
    logic [PIX_BITS-1:0] npix_q;

    assign pix_last  = pix == npix_q - 1'b1;
    assign next_last = ch + 1'b1 == nch_q - 1'b1;
    assign one_pix   = npix_q == 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nch_q  <= '0;
            npix_q <= '0;
            pix    <= '0;
            ch     <= '0;
        end else if (load) begin
            nch_q  <= num_ch;
            npix_q <= num_pix;
            pix    <= '0;
            ch     <= '0;
        end else if (adv) begin
            pix <= pix_last ? '0 : pix + 1'b1;
            ch  <= pix_last ? ch + 1'b1 : ch;
        end
    end

endmodule

// File: rtl/psum_ctrl.sv
// psum_ctrl: partial-sum accumulation controller sequencing psum buffer reads/writes and adder modes.
//   clk, rst                  clock, asynchronous active-high reset
//   start, num_ch, num_pix    job launch (sampled in IDLE) and geometry
//   pe_valid / pe_ready       PE beat handshake, transfer = pe_valid & pe_ready
//   mode, psum_zero           adder mode (00 first, 01 middle, 10 last) and psum operand zeroing
//   psum_rd_en/addr           buffer read issued in the transfer cycle
//   psum_wr_en/addr           adder result write, one cycle after the transfer
//   relu_en                   output ReLU on last-pass writes when PSUM_CTRL_RELU_EN is defined, else 0
//   busy, done, cfg_err       job status, end-of-job pulse, rejected-start pulse
module psum_ctrl
    import psum_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CH_BITS-1:0]  num_ch,
    input  logic [PIX_BITS-1:0] num_pix,
    input  logic                pe_valid,
    output logic                pe_ready,
    output logic [1:0]          mode,
    output logic                psum_zero,
    output logic                psum_rd_en,
    output logic [PIX_BITS-1:0] psum_rd_addr,
    output logic                psum_wr_en,
    output logic [PIX_BITS-1:0] psum_wr_addr,
    output logic                relu_en,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    state_t              state;
    logic                bubble;
    logic                zero_job;
    logic                s1_valid;
    mode_t               s1_mode;
    logic [PIX_BITS-1:0] s1_addr;
    logic [PIX_BITS-1:0] pix;
    logic [CH_BITS-1:0]  ch;
    logic                pix_last;
    logic                next_last;
    logic                one_pix;
    logic                ok_start;
    logic                active;
    logic                xfer;

    assign ok_start = state == S_IDLE && start && num_ch != '0 && num_pix != '0;
    assign active   = state == S_FIRST || state == S_ACC || state == S_LAST;
    assign pe_ready = active && !bubble;
    assign xfer     = pe_valid && pe_ready;

    psum_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ok_start),
        .num_ch    (num_ch),
        .num_pix   (num_pix),
        .adv       (xfer),
        .pix       (pix),
        .ch        (ch),
        .pix_last  (pix_last),
        .next_last (next_last),
        .one_pix   (one_pix)
    );

    // The first pass and single-pass jobs have no prior partial sum to fetch.
    assign psum_rd_en   = xfer && state != S_FIRST && !zero_job;
    assign psum_rd_addr = pix;
    assign psum_wr_en   = s1_valid;
    assign psum_wr_addr = s1_addr;
    // A write carries the mode of the pass its beat belonged to, even across a pass boundary.
    assign mode         = s1_valid ? s1_mode : state_mode(state);
    assign psum_zero    = zero_job;
    assign busy         = state != S_IDLE;

`ifdef PSUM_CTRL_RELU_EN
    assign relu_en = s1_valid && s1_mode == MODE_LAST;
`else
    assign relu_en = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bubble   <= 1'b0;
            zero_job <= 1'b0;
            s1_valid <= 1'b0;
            s1_mode  <= MODE_FIRST;
            s1_addr  <= '0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            s1_valid <= xfer;
            // With one pixel per pass the next read would hit the address being written.
            bubble   <= xfer && one_pix && state != S_LAST;
            if (xfer) begin
                s1_mode <= state_mode(state);
                s1_addr <= pix;
            end
            case (state)
                S_IDLE: begin
                    if (start && !ok_start)
                        cfg_err <= 1'b1;
                    if (ok_start) begin
                        zero_job <= num_ch == 1'b1;
                        state    <= num_ch == 1'b1 ? S_LAST : S_FIRST;
                    end
                end
                S_FIRST, S_ACC: begin
                    if (xfer && pix_last)
                        state <= next_last ? S_LAST : S_ACC;
                end
                S_LAST: begin
                    if (xfer && pix_last)
                        state <= S_FIN;
                end
                S_FIN: begin
                    if (s1_valid) begin
                        done     <= 1'b1;
                        zero_job <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_ctrl.sv
// tb_psum_ctrl: randomized self-checking bench for psum_ctrl against a pass/pixel reference model.
module tb_psum_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_ch = '0;
    logic [9:0] num_pix = '0;
    logic       pe_valid = 1'b0;
    logic       pe_ready;
    logic [1:0] mode;
    logic       psum_zero;
    logic       psum_rd_en;
    logic [9:0] psum_rd_addr;
    logic       psum_wr_en;
    logic [9:0] psum_wr_addr;
    logic       relu_en;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int addr;
        int mode;
    } wr_t;

    psum_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_ch       (num_ch),
        .num_pix      (num_pix),
        .pe_valid     (pe_valid),
        .pe_ready     (pe_ready),
        .mode         (mode),
        .psum_zero    (psum_zero),
        .psum_rd_en   (psum_rd_en),
        .psum_rd_addr (psum_rd_addr),
        .psum_wr_en   (psum_wr_en),
        .psum_wr_addr (psum_wr_addr),
        .relu_en      (relu_en),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, psum_wr_en, 0);
        chk({tag, "_rd_en"}, psum_rd_en, 0);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_ready"}, pe_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_zero"}, psum_zero, 0);
        chk({tag, "_relu"}, relu_en, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Runs one job; the expected write/read streams come from nested pass/pixel loops.
    task automatic run_job(input int nch, input int npix, input int pv_pct);
        wr_t wq[$];
        int  rq[$];
        wr_t w;
        int  total = nch * npix;
        int  ntx = 0;
        int  nwr = 0;
        int  last_wr_cyc = -10;
        bit  fin = 0;
        bit  bub = 0;
        bit  exp_rdy;
        bit  tx;
        int  exp_relu;
        for (int c = 0; c < nch; c++)
            for (int p = 0; p < npix; p++) begin
                w.addr = p;
                w.mode = (c == nch - 1) ? 2 : (c == 0) ? 0 : 1;
                wq.push_back(w);
                if (c > 0)
                    rq.push_back(p);
            end
        @(posedge clk); #1;
        start = 1'b1;
        num_ch = 8'(nch);
        num_pix = 10'(npix);
        @(posedge clk); #1;
        start = 1'b0;
        num_ch = '0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            pe_valid = $urandom_range(99) < pv_pct;
            start = (ntx < total) && ($urandom_range(7) == 0);
            @(negedge clk);
            exp_rdy = (ntx < total) && !bub;
            chk("ready", pe_ready, exp_rdy);
            tx = pe_valid && pe_ready;
            bub = tx && npix == 1 && (ntx / npix) < nch - 1;
            if (tx)
                ntx++;
            chk("cfg_err_busy", cfg_err, 0);
            if (psum_wr_en) begin
                if (wq.size() == 0)
                    chk("extra_wr", 1, 0);
                else begin
                    w = wq.pop_front();
`ifdef PSUM_CTRL_RELU_EN
                    exp_relu = (w.mode == 2) ? 1 : 0;
`else
                    exp_relu = 0;
`endif
                    chk("wr_addr", psum_wr_addr, w.addr);
                    chk("wr_mode", mode, w.mode);
                    chk("wr_zero", psum_zero, nch == 1);
                    chk("wr_relu", relu_en, exp_relu);
                end
                nwr++;
                if (nwr == total)
                    last_wr_cyc = cyc;
            end else
                chk("relu_idle", relu_en, 0);
            if (psum_rd_en) begin
                if (rq.size() == 0)
                    chk("extra_rd", 1, 0);
                else
                    chk("rd_addr", psum_rd_addr, rq.pop_front());
                chk("rd_wr_collision", psum_wr_en && psum_wr_addr == psum_rd_addr, 0);
            end
            if (done) begin
                chk("done_latency", cyc, last_wr_cyc + 1);
                chk("busy_at_done", busy, 0);
                fin = 1;
            end else
                chk("busy", busy, 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        pe_valid = 1'b0;
        chk("job_finished", fin, 1);
        chk("writes_left", wq.size(), 0);
        chk("reads_left", rq.size(), 0);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_after", busy, 0);
        chk("cfg_err_after", cfg_err, 0);
    endtask

    task automatic bad_start(input int nch, input int npix);
        @(posedge clk); #1;
        start = 1'b1;
        num_ch = 8'(nch);
        num_pix = 10'(npix);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy0", busy, 0);
        @(negedge clk);
        chk("cfg_err_once", cfg_err, 0);
        chk("cfg_err_idle", busy, 0);
    endtask

    initial begin
        #2;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_job(3, 4, 100);
        run_job(1, 5, 100);
        run_job(2, 1, 100);
        bad_start(0, 5);
        bad_start(3, 0);
        run_job(4, 7, 60);

        // Mid-job reset while the ACC pass handles pixel 2.
        @(posedge clk); #1;
        start = 1'b1;
        num_ch = 8'd3;
        num_pix = 10'd4;
        pe_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_rd_en", psum_rd_en, 1);
        chk("pre_rst_rd_addr", psum_rd_addr, 2);
        chk("pre_rst_mode", mode, 1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        pe_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_wr", psum_wr_en, 0);
            chk("midrst_no_done", done, 0);
        end
        rst = 1'b0;
        run_job(3, 4, 100);

        for (int i = 0; i < 6; i++)
            run_job($urandom_range(1, 5), $urandom_range(1, 6), $urandom_range(30, 100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_ctrl.md
PSUM_CTRL -- requirements
Module: psum_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous, active-high reset; the block has one clock only.
REQ-003 start  in  1  single-cycle pulse; sampled only in IDLE.
REQ-004 num_ch  in  8  input-channel count per job; latched on accepted start.
REQ-005 num_pix  in  10  output pixels per channel pass; latched on accepted start.
REQ-006 pe_valid  in  1  PE array presents one 3-product beat (Data_in1..3).
REQ-007 pe_ready  out  1  controller accepts the beat; transfer = pe_valid & pe_ready.
REQ-008 mode  out  2  Adder Mode: 00 first pass, 01 middle pass, 10 last pass (bias added).
REQ-009 psum_zero  out  1  forces the Adder Psum operand to 0.
REQ-010 psum_rd_en / psum_rd_addr  out  1 / 10  psum buffer synchronous read, 1-cycle latency.
REQ-011 psum_wr_en / psum_wr_addr  out  1 / 10  write of Adder Result into psum buffer.
REQ-012 relu_en  out  1  output-stage ReLU enable (see Configuration).
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse at job end.
REQ-015 cfg_err  out  1  one-cycle pulse when start is rejected.

Function
REQ-016 FSM states: IDLE, FIRST, ACC, LAST, FIN; current state held in a state register.
REQ-017 IDLE + start with num_ch==0 or num_pix==0: pulse cfg_err next cycle, remain IDLE.
REQ-018 IDLE + valid start: num_ch==1 -> LAST with psum_zero=1 for the whole pass; else -> FIRST.
REQ-019 Pixel counter pix counts accepted beats 0..num_pix-1; channel counter ch counts passes 0..num_ch-1.
REQ-020 On the transfer with pix==num_pix-1: pix wraps to 0, ch increments; FIRST->ACC (or ->LAST if num_ch==2), ACC->LAST when new ch==num_ch-1, LAST->FIN.
REQ-021 Transfer at pix=p: psum_rd_en=1, psum_rd_addr=p in the same cycle (suppressed in FIRST and when psum_zero).
REQ-022 Stage 1 (next cycle): psum_wr_en=1, psum_wr_addr=p, mode = registered mode of the transfer pass; the datapath registers Data_in1..3 in step.
REQ-023 Transfer-to-write latency is exactly 1 cycle; throughput is 1 beat/cycle.
REQ-024 pe_ready=1 in FIRST/ACC/LAST except the hazard bubble below; 0 in IDLE and FIN.
REQ-025 Hazard: when num_pix==1, pe_ready drops for exactly one cycle after each transfer that is not in the last pass, so no read can coincide with the write to the same address.
REQ-026 mode=00 in FIRST, 01 in ACC, 10 in LAST; mode=00 in IDLE/FIN; 11 is never driven.
REQ-027 FIN: wait for the last stage-1 write, pulse done, then return to IDLE; done follows the final write by 1 cycle.
REQ-028 start while busy is ignored; no cfg_err pulse.

Reset
REQ-029 rst asynchronously forces: state=IDLE, pix=0, ch=0, stage-1 valid=0.
REQ-030 All outputs are 0 during reset, including mode=00 and every write enable.
REQ-031 rst mid-job drops any in-flight stage-1 write and abandons the job; no done pulse.

Configuration
REQ-032 Macro PSUM_CTRL_RELU_EN: defined -> relu_en=1 exactly on stage-1 writes of the LAST pass.
REQ-033 Macro not defined -> relu_en is tied to 0; all other behaviour is identical.

Structure
REQ-034 Shared include def.v holds the FSM state encodings, the mode codes (MODE_FIRST=00, MODE_ACC=01, MODE_LAST=10), and the PIX_BITS=10 and CH_BITS=8 widths; INTERNAL_BITS and DATA_BITS stay there.
REQ-035 One sub-module, psum_addr_gen, holds the pix/ch counters and their wrap logic; the FSM and stage-1 registers stay at the top.

Verification
REQ-036 num_ch=3, num_pix=4, pe_valid held high -> 12 transfers; mode sequence 00x4, 01x4, 10x4 on writes; done 1 cycle after the 12th write.
REQ-037 num_ch=1, num_pix=5 -> mode=10 and psum_zero=1 on all 5 writes; psum_rd_en never asserted.
REQ-038 num_ch=2, num_pix=1 -> one-cycle pe_ready bubble after the first transfer; the read of address 0 occurs after the write of address 0.
REQ-039 num_pix=0 or num_ch=0 with start -> cfg_err pulse; busy stays 0.
REQ-040 rst asserted during ACC at pix=2 -> outputs go to 0 immediately, no write follows, no done pulse; the next valid start runs cleanly.
REQ-041 pe_valid toggled randomly, num_ch=4, num_pix=7 -> the write address/mode stream matches the ideal sequence; with PSUM_CTRL_RELU_EN, relu_en is high only on the 7 LAST-pass writes.
